encoder_scanner: RTL and testbench

//  Front end for the rotary encoder bank. Drives the select lines of the external

---
 rtl/encoder_scanner.sv | 120 ++++++++++++
 tb/tb_encoder_scanner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/encoder_scanner.sv
// Multiplexed quadrature encoder scanner: walks the external mux across CHANNELS
// encoders, debounces each channel over two visits and emits one step per transition.
module encoder_scanner #(
  parameter int CHANNELS      = 8,
  parameter int SEL_WIDTH     = 3,
  parameter int SETTLE_CYCLES = 32,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a,
  input  logic                 b,
  output logic [SEL_WIDTH-1:0] mux_sel,
  output logic                 step_valid,
  input  logic                 step_ready,
  output logic [SEL_WIDTH-1:0] step_ch,
  output logic                 step_dir,
  output logic                 err_stb,
  output logic [SEL_WIDTH-1:0] err_ch
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_WIDTH-1:0] LAST_CH  = SEL_WIDTH'(CHANNELS - 1);

  typedef enum logic [1:0] {SETTLE, SAMPLE, EMIT, ADVANCE} state_t;

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [SYNC_STAGES-1:0] a_sync_p, b_sync_p;
  logic [1:0]           raw [CHANNELS];
  logic [1:0]           acc [CHANNELS];
  logic [CHANNELS-1:0]  init;

  logic [1:0] s, raw_cur, acc_cur;
  logic       accepted, moved, illegal, dir;

  // Clockwise sequence 00->01->11->10->00; anything else single-bit is CCW.
  function automatic logic cw_step(input logic [1:0] from, input logic [1:0] to);
    case ({from, to})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: cw_step = 1'b1;
      default:                            cw_step = 1'b0;
    endcase
  endfunction

  // Stage: input synchronisers (no reset, pure data)
  always_ff @(posedge clk) begin
    a_sync_p <= {a_sync_p[SYNC_STAGES-2:0], a};
    b_sync_p <= {b_sync_p[SYNC_STAGES-2:0], b};
  end

  always_comb begin
    s        = {a_sync_p[SYNC_STAGES-1], b_sync_p[SYNC_STAGES-1]};
    raw_cur  = raw[mux_sel];
    acc_cur  = acc[mux_sel];
    accepted = (s == raw_cur);
    moved    = accepted && init[mux_sel] && (s != acc_cur);
    illegal  = (s == ~acc_cur);
    dir      = cw_step(acc_cur, s);
  end

  always_comb begin
    state_nx = state;
    case (state)
      SETTLE:  if (cnt == LAST_CNT) state_nx = SAMPLE;
      SAMPLE:  state_nx = (moved && !illegal) ? EMIT : ADVANCE;
      EMIT:    if (step_valid && step_ready) state_nx = ADVANCE;
      ADVANCE: state_nx = SETTLE;
      default: state_nx = SETTLE;
    endcase
  end

  // Stage: scan control and event registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SETTLE;
      cnt        <= '0;
      mux_sel    <= '0;
      step_valid <= 1'b0;
      step_ch    <= '0;
      step_dir   <= 1'b0;
      err_stb    <= 1'b0;
      err_ch     <= '0;
      init       <= '0;
    end else begin
      state   <= state_nx;
      err_stb <= 1'b0;
      case (state)
        SETTLE: cnt <= cnt + 1'b1;
        SAMPLE: begin
          if (accepted) init[mux_sel] <= 1'b1;
          if (moved && !illegal) begin
            step_valid <= 1'b1;
            step_ch    <= mux_sel;
            step_dir   <= dir;
          end
          if (moved && illegal) begin
            err_stb <= 1'b1;
            err_ch  <= mux_sel;
          end
        end
        EMIT: if (step_valid && step_ready) step_valid <= 1'b0;
        ADVANCE: begin
          mux_sel <= (mux_sel == LAST_CH) ? '0 : mux_sel + 1'b1;
          cnt     <= '0;
        end
        default: ;
      endcase
    end
  end

  // Stage: per-channel sample history (data, not reset)
  always_ff @(posedge clk) begin
    if (state == SAMPLE) begin
      raw[mux_sel] <= s;
      if (accepted) acc[mux_sel] <= s;
    end
  end

endmodule

// File: tb/tb_encoder_scanner.sv
// Scoreboard bench for encoder_scanner: a behavioural mux feeds per-channel
// encoder states; expected step/error events are queued and popped by a monitor.
module tb_encoder_scanner;

  localparam int CH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       a, b;
  logic [2:0] mux_sel, step_ch, err_ch;
  logic       step_valid, step_ready, step_dir, err_stb;
  logic [1:0] enc [CH];

  int n_cmp  = 0;
  int n_fail = 0;
  logic [4:0] exp_q [$];   // {is_err, ch[2:0], dir}
  logic err_prev = 1'b0;

  always #5 clk = ~clk;

  assign a = enc[mux_sel][1];
  assign b = enc[mux_sel][0];

  encoder_scanner #(
    .CHANNELS(8), .SEL_WIDTH(3), .SETTLE_CYCLES(32), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .mux_sel(mux_sel),
    .step_valid(step_valid), .step_ready(step_ready), .step_ch(step_ch),
    .step_dir(step_dir), .err_stb(err_stb), .err_ch(err_ch)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits until the scanner has visited and left channel ch once.
  task automatic wait_leave(input int ch);
    int k = 0;
    while (mux_sel != 3'(ch) && k < 2000) begin tick(); k++; end
    while (mux_sel == 3'(ch) && k < 2000) begin tick(); k++; end
    if (k >= 2000) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_leave_ch%0d: timeout, required a visit", ch);
    end
  endtask

  task automatic wait_valid();
    int k = 0;
    while (step_valid !== 1'b1 && k < 2000) begin tick(); k++; end
    check("valid_rise", step_valid, 1);
  endtask

  always @(negedge clk) begin
    logic [4:0] e;
    if (!rst) begin
      if (step_valid && step_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_step: ch %0d dir %0d, required no event", step_ch, step_dir);
        end else begin
          e = exp_q.pop_front();
          check("step_kind", 0, e[4]);
          check("step_ch", step_ch, e[3:1]);
          check("step_dir", step_dir, e[0]);
        end
      end
      if (err_stb) begin
        check("err_pulse_width", err_prev, 0);
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_err: ch %0d, required no event", err_ch);
        end else begin
          e = exp_q.pop_front();
          check("err_kind", 1, e[4]);
          check("err_ch", err_ch, e[3:1]);
        end
      end
    end
    err_prev <= err_stb;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev, changes, wraps, k;
    logic stable;
    rst = 1'b1;
    step_ready = 1'b1;
    for (int i = 0; i < CH; i++) enc[i] = 2'b00;
    repeat (3) tick();
    check("rst_mux_sel", mux_sel, 0);
    check("rst_step_valid", step_valid, 0);
    check("rst_step_ch", step_ch, 0);
    check("rst_step_dir", step_dir, 0);
    check("rst_err_stb", err_stb, 0);
    check("rst_err_ch", err_ch, 0);
    rst = 1'b0;

    // Idle scan: three full rotations, sequence must step by one and wrap.
    prev = mux_sel; changes = 0; wraps = 0; k = 0;
    while (changes < 24 && k < 3000) begin
      tick(); k++;
      if (mux_sel != 3'(prev)) begin
        check("scan_seq", mux_sel, (prev + 1) % CH);
        if (mux_sel == 3'd0) wraps++;
        prev = mux_sel;
        changes++;
      end
    end
    check("scan_wraps", wraps, 3);

    // ch3: 00 -> 01 -> 11, both clockwise.
    wait_leave(3);
    enc[3] = 2'b01; exp_q.push_back({1'b0, 3'd3, 1'b1});
    wait_leave(3); wait_leave(3);
    enc[3] = 2'b11; exp_q.push_back({1'b0, 3'd3, 1'b1});
    wait_leave(3); wait_leave(3);

    // ch5: 00 -> 10, counter-clockwise.
    wait_leave(5);
    enc[5] = 2'b10; exp_q.push_back({1'b0, 3'd5, 1'b0});
    wait_leave(5); wait_leave(5);

    // ch2: single-visit bounce must be rejected.
    wait_leave(2);
    enc[2] = 2'b01;
    wait_leave(2);
    enc[2] = 2'b00;
    wait_leave(2); wait_leave(2);

    // ch6: 00 -> 11 is illegal, then 11 -> 10 is clockwise.
    wait_leave(6);
    enc[6] = 2'b11; exp_q.push_back({1'b1, 3'd6, 1'b0});
    wait_leave(6); wait_leave(6);
    enc[6] = 2'b10; exp_q.push_back({1'b0, 3'd6, 1'b1});
    wait_leave(6); wait_leave(6);
    check("queue_drained_mid", exp_q.size(), 0);

    // ch1: stall in EMIT for 100 cycles, then one handshake.
    wait_leave(1);
    step_ready = 1'b0;
    enc[1] = 2'b01; exp_q.push_back({1'b0, 3'd1, 1'b1});
    wait_valid();
    check("stall_ch", step_ch, 1);
    check("stall_dir", step_dir, 1);
    check("stall_sel", mux_sel, 1);
    stable = 1'b1;
    repeat (100) begin
      tick();
      if (step_valid !== 1'b1 || step_ch !== 3'd1 || step_dir !== 1'b1 || mux_sel !== 3'd1)
        stable = 1'b0;
    end
    check("stall_stable", stable, 1);
    step_ready = 1'b1;
    tick();
    check("valid_drop", step_valid, 0);
    check("sel_held_advance", mux_sel, 1);
    tick();
    check("advance_sel", mux_sel, 2);
    check("queue_drained_stall", exp_q.size(), 0);

    // ch1: 01 -> 11 pending, reset while EMIT holds valid high.
    step_ready = 1'b0;
    enc[1] = 2'b11;
    wait_valid();
    check("pre_rst_dir", step_dir, 1);
    rst = 1'b1;
    tick();
    check("emit_rst_valid", step_valid, 0);
    check("emit_rst_sel", mux_sel, 0);
    check("emit_rst_ch", step_ch, 0);
    check("emit_rst_dir", step_dir, 0);
    check("emit_rst_err", err_stb, 0);
    check("emit_rst_err_ch", err_ch, 0);
    rst = 1'b0;
    step_ready = 1'b1;
    repeat (5) tick();
    check("queue_drained_end", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
